// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush, NOP bubbles and an
// optional two-entry skid buffer that takes out_ready off the in_ready path.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | no beat held (main and skid slots invalid)
// ST_BUSY  | main slot valid, skid slot empty
// ST_FULL  | main and skid slots valid (SKID=1 only)

module if_id_pipe_reg #(
  parameter int unsigned      IR_W   = 32,
  parameter int unsigned      NPC_W  = 32,
  parameter bit               SKID   = 1'b1,
  parameter logic [IR_W-1:0]  NOP_IR = {IR_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  in_ir,
  input  logic [NPC_W-1:0] in_npc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IR_W-1:0]  out_ir,
  output logic [NPC_W-1:0] out_npc
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IR_W-1:0]  m_ir, s_ir;
  logic [NPC_W-1:0] m_npc, s_npc;
  logic             accept, consume;
  logic             load_m_in, load_m_s, load_s;

  // With the skid buffer, in_ready is a pure decode of the state register.
  assign in_ready  = SKID ? (state != ST_FULL) : ((state == ST_EMPTY) | out_ready);
  assign out_valid = (state != ST_EMPTY);
  assign out_ir    = out_valid ? m_ir : NOP_IR;
  assign out_npc   = m_npc;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_BUSY;
          load_m_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (accept && consume) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          if (SKID) begin
            state_nxt = ST_FULL;
            load_s    = 1'b1;
          end else begin
            load_m_in = 1'b1;
          end
        end else if (consume) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_nxt = ST_BUSY;
          load_m_s  = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush drops everything held and the incoming beat; data regs keep old values.
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ir  <= {IR_W{1'b0}};
      m_npc <= {NPC_W{1'b0}};
      s_ir  <= {IR_W{1'b0}};
      s_npc <= {NPC_W{1'b0}};
    end else begin
      if (load_m_in) begin
        m_ir  <= in_ir;
        m_npc <= in_npc;
      end else if (load_m_s) begin
        m_ir  <= s_ir;
        m_npc <= s_npc;
      end
      if (load_s) begin
        s_ir  <= in_ir;
        s_npc <= in_npc;
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: drives a SKID=0 and a SKID=1 instance with the same
// stimulus and checks both against a queue model every cycle, plus literal checks.

module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_ir, in_npc;
  logic [1:0]  in_ready, out_valid;
  logic [31:0] out_ir  [2];
  logic [31:0] out_npc [2];

  int vectors     = 0;
  int miscompares = 0;

  // Model: per instance, an ordered list of held beats plus the last head npc.
  logic [31:0] q_ir  [2][2];
  logic [31:0] q_npc [2][2];
  int          cnt   [2];
  logic [31:0] held  [2];

  localparam logic [31:0] IR_A = 32'h0022_1820;
  localparam logic [31:0] IR_B = 32'h0022_1824;
  localparam logic [31:0] IR_C = 32'h0022_1828;

  if_id_pipe_reg #(.IR_W(32), .NPC_W(32), .SKID(1'b0), .NOP_IR(32'h0)) u_skid0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_ir(in_ir), .in_npc(in_npc),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_ir(out_ir[0]), .out_npc(out_npc[0])
  );

  if_id_pipe_reg #(.IR_W(32), .NPC_W(32), .SKID(1'b1), .NOP_IR(32'h0)) u_skid1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_ir(in_ir), .in_npc(in_npc),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_ir(out_ir[1]), .out_npc(out_npc[1])
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready(int k);
    if (k == 1) return (cnt[k] < 2);
    return (cnt[k] == 0) || out_ready;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d out_valid", k), 32'(out_valid[k]), 32'(cnt[k] > 0));
      chk($sformatf("u%0d out_ir", k), out_ir[k], (cnt[k] > 0) ? q_ir[k][0] : 32'h0);
      chk($sformatf("u%0d out_npc", k), out_npc[k], (cnt[k] > 0) ? q_npc[k][0] : held[k]);
      chk($sformatf("u%0d in_ready", k), 32'(in_ready[k]), 32'(exp_ready(k)));
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] ir, input logic [31:0] npc, input logic ordy);
    bit acc [2];
    bit con;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_ir = ir; in_npc = npc; out_ready = ordy;
    #1;
    compare_all();
    for (int k = 0; k < 2; k++) acc[k] = iv && exp_ready(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        cnt[k]  = 0;
        held[k] = 32'h0;
      end else begin
        con = (cnt[k] > 0) && ordy;
        if (con) begin
          q_ir[k][0]  = q_ir[k][1];
          q_npc[k][0] = q_npc[k][1];
          cnt[k]--;
        end
        if (f) begin
          cnt[k] = 0;
        end else if (acc[k]) begin
          q_ir[k][cnt[k]]  = ir;
          q_npc[k][cnt[k]] = npc;
          cnt[k]++;
        end
        if (cnt[k] > 0) held[k] = q_npc[k][0];
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ir = 32'h2002_0005; in_npc = 32'd4;
    out_ready = 1'b1;
    cnt[0] = 0; cnt[1] = 0; held[0] = 32'h0; held[1] = 32'h0;

    // reset with a beat presented
    step(1'b1, 1'b0, 1'b1, 32'h2002_0005, 32'd4, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h2002_0005, 32'd4, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("reset out_valid", 32'(out_valid[k]), 32'd0);
      chk("reset out_ir", out_ir[k], 32'h0);
      chk("reset out_npc", out_npc[k], 32'h0);
      chk("reset in_ready", 32'(in_ready[k]), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("post-reset no beat", 32'(out_valid[1]), 32'd0);

    // streaming
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h8C01_0000 + 32'(i), 32'(4 * (i + 1)), 1'b1);
      for (int k = 0; k < 2; k++) begin
        chk("stream out_ir", out_ir[k], 32'h8C01_0000 + 32'(i));
        chk("stream out_npc", out_npc[k], 32'(4 * (i + 1)));
        chk("stream in_ready", 32'(in_ready[k]), 32'd1);
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain npc held", out_npc[1], 32'd16);
    chk("drain out_ir nop", out_ir[1], 32'h0);

    // stall: SKID=1 absorbs B into skid slot, SKID=0 refuses it
    step(1'b0, 1'b0, 1'b1, IR_A, 32'd100, 1'b1);
    chk("stall A loaded", out_ir[1], IR_A);
    step(1'b0, 1'b0, 1'b1, IR_B, 32'd104, 1'b0);
    chk("skid1 full in_ready", 32'(in_ready[1]), 32'd0);
    chk("skid1 holds A", out_ir[1], IR_A);
    chk("skid0 stall in_ready", 32'(in_ready[0]), 32'd0);
    chk("skid0 holds A", out_ir[0], IR_A);
    step(1'b0, 1'b0, 1'b1, IR_C, 32'd108, 1'b0);
    chk("skid0 still A", out_ir[0], IR_A);
    chk("skid1 still A", out_ir[1], IR_A);

    // flush in FULL with incoming C
    step(1'b0, 1'b1, 1'b1, IR_C, 32'd108, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("flush out_valid", 32'(out_valid[k]), 32'd0);
      chk("flush out_ir", out_ir[k], 32'h0);
      chk("flush in_ready", 32'(in_ready[k]), 32'd1);
    end
    chk("flush npc held", out_npc[1], 32'd100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("flush nothing left", 32'(out_valid[1]), 32'd0);

    // drain FULL in order
    step(1'b0, 1'b0, 1'b1, IR_A, 32'd200, 1'b1);
    step(1'b0, 1'b0, 1'b1, IR_B, 32'd204, 1'b0);
    chk("drain full in_ready", 32'(in_ready[1]), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain B out_ir", out_ir[1], IR_B);
    chk("drain B out_npc", out_npc[1], 32'd204);
    chk("drain in_ready back", 32'(in_ready[1]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain empty", 32'(out_valid[1]), 32'd0);

    // reset beats simultaneous accept and consume
    step(1'b0, 1'b0, 1'b1, IR_A, 32'd300, 1'b1);
    step(1'b1, 1'b0, 1'b1, IR_B, 32'd304, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("rst-wins out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst-wins out_ir", out_ir[k], 32'h0);
      chk("rst-wins out_npc", out_npc[k], 32'h0);
      chk("rst-wins in_ready", 32'(in_ready[k]), 32'd1);
    end

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), $urandom, $urandom,
           ($urandom_range(0, 2) != 0));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline register that carries a fetched instruction word and its next-PC from the fetch stage to the decode stage. It is a clocked stage with a valid/ready handshake, stall back-pressure, synchronous flush for branch/jump redirects, and NOP-bubble output. An optional two-entry skid buffer registers the upstream ready, which breaks the combinational ready path from decode back to fetch.

## Interface
- IR_W, 32, instruction word width
- NPC_W, 32, next-PC width
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- NOP_IR, 32'h0000_0000, value driven on out_ir whenever out_valid=0 (width IR_W)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming entries (branch redirect)
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage can accept a beat this cycle
- in_ir  in  IR_W  fetched instruction
- in_npc  in  NPC_W  PC+4 of fetched instruction
- out_valid  out  1  decode-side beat valid
- out_ready  in  1  decode accepts the beat this cycle
- out_ir  out  IR_W  instruction to decode (NOP_IR when invalid)
- out_npc  out  NPC_W  next-PC to decode (held value when invalid; 0 after reset)

## Operation
- Accept: in_valid & in_ready at an edge. Consume: out_valid & out_ready at an edge.
- Order is strictly FIFO; no beat is duplicated or dropped except by flush or reset.
- SKID=1 state machine (main slot M, skid slot S):
  - EMPTY (M,S invalid): accept -> BUSY.
  - BUSY (M valid): accept & consume -> BUSY (new beat into M); accept only -> FULL (beat into S); consume only -> EMPTY.
  - FULL (M,S valid): in_ready=0; consume -> BUSY with S moved to M.
  - in_ready = ~S.valid (register-driven).
- SKID=0: single slot M; in_ready = ~M.valid | out_ready; accept & consume in the same cycle replaces M.
- out_valid = M.valid; out_ir = M.valid ? M.ir : NOP_IR; out_npc = M.npc.
- While out_valid & ~out_ready, out_ir/out_npc are held stable.
- Flush: at the edge, M.valid and S.valid clear to 0. A beat accepted in the same cycle is discarded. A beat consumed in the same cycle counts as consumed (decode owns the squash decision). Next state is EMPTY.
- Priority: rst > flush > accept/consume.

## Timing
- Reset values (after the first edge with rst=1): out_valid=0, out_ir=NOP_IR, out_npc=0, in_ready=1, state EMPTY. Inputs are ignored while rst=1.
- Reset mid-operation discards M and S, with no partial update.
- Latency: accept at edge N -> out_valid=1 with that data after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained when out_ready=1.
- SKID=1: after out_ready deasserts, in_ready falls one cycle later at most, and at most one extra beat is absorbed into S. in_ready rises in the cycle after S drains.
- SKID=0: in_ready follows out_ready combinationally; no extra storage.
- in_ready does not depend on in_valid in either mode.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, in_ir=32'h2002_0005 -> out_valid=0, out_ir=32'h0000_0000, out_npc=0, in_ready=1; no beat appears after rst falls.
- Streaming: out_ready=1, feed ir=32'h8C01_0000..+3 with npc=4,8,12,16 on consecutive cycles -> identical sequence out one cycle later, no bubbles, in_ready stays 1.
- Stall (SKID=1): in BUSY with ir A=32'h0022_1820, drop out_ready while beat B is accepted -> state FULL, in_ready=0, out_ir holds A. Raise out_ready -> A then B delivered in order, in_ready=1 after S drains.
- Stall (SKID=0): out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; in_valid held high is not accepted and out_ir is unchanged.
- Flush: in FULL, assert flush together with an incoming beat C -> next cycle out_valid=0, out_ir=NOP_IR, in_ready=1; C, A and B never appear.
- Simultaneous accept+consume+rst: rst wins -> all outputs at reset values.
